// File: rtl/fifo_reader_pkg.sv
// Shared constants and the reader FSM encoding for the FIFO consumer front end.
package fifo_reader_pkg;

   localparam int unsigned FifoW     = 4;
   localparam int unsigned FifoDepth = 8;

   typedef enum logic {
      StIdle = 1'b0,
      StWait = 1'b1
   } rd_state_e;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus the downstream valid/ready stream of the reader.
interface fifo_reader_if
   import fifo_reader_pkg::*;
#(
   parameter int unsigned Width = FifoW
);
   logic             empty;
   logic [Width-1:0] out;
   logic             deq;
   logic [Width-1:0] dout;
   logic             dvalid;
   logic             dready;

   modport master (
      input  empty,
      input  out,
      input  dready,
      output deq,
      output dout,
      output dvalid
   );

   modport slave (
      output empty,
      output out,
      output dready,
      input  deq,
      input  dout,
      input  dvalid
   );
endinterface

// File: rtl/reader_skid_buf.sv
// Two-entry circular valid/ready buffer; flush clears it ahead of any push or pop.
module reader_skid_buf #(
   parameter int unsigned Width = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [Width-1:0] push_data_i,
   input  logic             pop_i,
   output logic [Width-1:0] data_o,
   output logic             valid_o,
   output logic [1:0]       count_o
);

   logic [Width-1:0] mem_q [2];
   logic [Width-1:0] mem_d [2];
   logic             rd_q, rd_d;
   logic             wr_q, wr_d;
   logic [1:0]       count_q, count_d;

   always_comb begin
      mem_d   = mem_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      count_d = count_q;
      if (flush_i) begin
         rd_d    = 1'b0;
         wr_d    = 1'b0;
         count_d = 2'd0;
      end else begin
         if (push_i) begin
            mem_d[wr_q] = push_data_i;
            wr_d        = ~wr_q;
         end
         if (pop_i) begin
            rd_d = ~rd_q;
         end
         count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         count_q  <= count_d;
      end
   end

   assign valid_o = (count_q != 2'd0);
   assign data_o  = valid_o ? mem_q[rd_q] : '0;
   assign count_o = count_q;

endmodule

// File: rtl/fifo_reader.sv
// Paced FIFO consumer: issues spaced deq pulses and streams popped words through a skid buffer.
module fifo_reader
   import fifo_reader_pkg::*;
#(
   parameter int unsigned Width = FifoW,
   parameter int unsigned Gap   = 2,
   parameter int unsigned CntW  = 8
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            en_i,
   input  logic            flush_i,
   fifo_reader_if.master   bus,
   output logic [CntW-1:0] pop_cnt_o,
   output logic            busy_o
);

   localparam int unsigned GapW = (Gap > 1) ? $clog2(Gap) : 1;
   localparam logic [GapW-1:0] GapLoad = GapW'(Gap - 1);

   rd_state_e        state_q, state_d;
   logic [GapW-1:0]  gap_q, gap_d;
   logic [CntW-1:0]  pop_cnt_q, pop_cnt_d;
   logic             run_q;
   logic             push;
   logic             accept;
   logic             buf_valid;
   logic [Width-1:0] buf_data;
   logic [1:0]       buf_count;

   // run_q holds off the first pop until one edge after reset release.
   assign push   = (state_q == StIdle) && run_q && en_i && !bus.empty && !flush_i &&
                   (buf_count < 2'd2);
   assign accept = buf_valid && bus.dready;

   always_comb begin
      state_d   = state_q;
      gap_d     = gap_q;
      pop_cnt_d = pop_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (push) begin
               state_d   = StWait;
               gap_d     = GapLoad;
               pop_cnt_d = pop_cnt_q + 1'b1;
            end
         end
         StWait: begin
            if (gap_q == '0) begin
               state_d = StIdle;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      if (flush_i) begin
         state_d = StIdle;
         gap_d   = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         gap_q     <= '0;
         pop_cnt_q <= '0;
         run_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         gap_q     <= gap_d;
         pop_cnt_q <= pop_cnt_d;
         run_q     <= 1'b1;
      end
   end

   reader_skid_buf #(
      .Width (Width)
   ) u_skid_buf (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .push_i      (push),
      .push_data_i (bus.out),
      .pop_i       (accept),
      .data_o      (buf_data),
      .valid_o     (buf_valid),
      .count_o     (buf_count)
   );

   assign bus.deq    = push;
   assign bus.dout   = buf_data;
   assign bus.dvalid = buf_valid;
   assign pop_cnt_o  = pop_cnt_q;
   assign busy_o     = (state_q != StIdle) || buf_valid;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a queue-based FIFO model on the read port.
module tb_fifo_reader;
   import fifo_reader_pkg::*;

   localparam int unsigned W    = FifoW;
   localparam int unsigned Gap  = 2;
   localparam int unsigned CntW = 2;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b0;
   logic            en    = 1'b0;
   logic            flush = 1'b0;
   logic [CntW-1:0] pop_cnt;
   logic            busy;

   fifo_reader_if #(.Width(W)) bus ();

   fifo_reader #(
      .Width (W),
      .Gap   (Gap),
      .CntW  (CntW)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .en_i      (en),
      .flush_i   (flush),
      .bus       (bus),
      .pop_cnt_o (pop_cnt),
      .busy_o    (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] fifo_q[$];

   typedef struct {
      logic            en;
      logic            dready;
      logic            flush;
      logic            exp_deq;
      logic            exp_dvalid;
      logic [W-1:0]    exp_dout;
      logic [CntW-1:0] exp_pc;
      logic            exp_busy;
   } vec_t;

   vec_t vt[11];

   task automatic fifo_update();
      bus.empty = (fifo_q.size() == 0);
      bus.out   = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   endtask

   always @(posedge clk) begin
      if (rst_n && bus.deq && fifo_q.size() != 0) begin
         void'(fifo_q.pop_front());
         fifo_update();
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n_deq;
      int n_dv;
      int n_busy;
      logic seen;

      vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0};
      vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h2, 2'd1, 1'b1};
      vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2'd1, 1'b1};
      vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 2'd1, 1'b0};
      vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 2'd2, 1'b1};
      vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2'd2, 1'b1};
      vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 2'd2, 1'b0};
      vt[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h4, 2'd3, 1'b1};
      vt[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2'd3, 1'b1};
      vt[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2'd3, 1'b0};
      vt[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2'd3, 1'b0};

      // Reset hold with a non-empty FIFO, then release.
      fifo_q = {4'h5};
      fifo_update();
      en = 1'b1;
      bus.dready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_deq", 32'(bus.deq), 32'd0);
      chk("rst_dvalid", 32'(bus.dvalid), 32'd0);
      chk("rst_dout", 32'(bus.dout), 32'd0);
      chk("rst_pop_cnt", 32'(pop_cnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("release_deq_low", 32'(bus.deq), 32'd0);
      step();
      chk("first_deq", 32'(bus.deq), 32'd1);
      step();
      chk("first_dout", 32'(bus.dout), 32'h5);
      chk("first_dvalid", 32'(bus.dvalid), 32'd1);
      chk("first_pop_cnt", 32'(pop_cnt), 32'd1);
      chk("first_deq_done", 32'(bus.deq), 32'd0);

      // Paced drain, table-driven cycle by cycle.
      fifo_q = {4'h2, 4'h3, 4'h4};
      fifo_update();
      en = 1'b1;
      bus.dready = 1'b1;
      do_reset();
      for (int i = 0; i < 11; i++) begin
         en = vt[i].en;
         bus.dready = vt[i].dready;
         flush = vt[i].flush;
         #1;
         chk($sformatf("drain%0d_deq", i), 32'(bus.deq), 32'(vt[i].exp_deq));
         chk($sformatf("drain%0d_dvalid", i), 32'(bus.dvalid), 32'(vt[i].exp_dvalid));
         chk($sformatf("drain%0d_dout", i), 32'(bus.dout), 32'(vt[i].exp_dout));
         chk($sformatf("drain%0d_pop_cnt", i), 32'(pop_cnt), 32'(vt[i].exp_pc));
         chk($sformatf("drain%0d_busy", i), 32'(busy), 32'(vt[i].exp_busy));
         step();
      end

      // Back-pressure: two pops then stall.
      fifo_q = {4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
      fifo_update();
      bus.dready = 1'b0;
      do_reset();
      n_deq = 0;
      for (int i = 0; i < 15; i++) begin
         if (bus.deq) n_deq++;
         step();
      end
      chk("bp_deq_count", 32'(n_deq), 32'd2);
      chk("bp_dout_held", 32'(bus.dout), 32'hA);
      chk("bp_dvalid", 32'(bus.dvalid), 32'd1);
      chk("bp_fifo_left", 32'(fifo_q.size()), 32'd3);
      chk("bp_deq_stalled", 32'(bus.deq), 32'd0);
      bus.dready = 1'b1;
      #1;
      chk("bp_accept_dout", 32'(bus.dout), 32'hA);
      step();
      bus.dready = 1'b0;
      #1;
      chk("bp_next_dout", 32'(bus.dout), 32'hB);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (bus.deq) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      chk("bp_third_pop", 32'(seen), 32'd1);
      step();
      chk("bp_pop_cnt", 32'(pop_cnt), 32'd3);
      chk("bp_dout_after", 32'(bus.dout), 32'hB);

      // Empty FIFO: nothing ever happens.
      fifo_q = {};
      fifo_update();
      bus.dready = 1'b1;
      do_reset();
      n_deq = 0;
      n_dv = 0;
      n_busy = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.deq) n_deq++;
         if (bus.dvalid) n_dv++;
         if (busy) n_busy++;
         step();
      end
      chk("empty_deq", 32'(n_deq), 32'd0);
      chk("empty_dvalid", 32'(n_dv), 32'd0);
      chk("empty_busy", 32'(n_busy), 32'd0);

      // Flush with a full buffer and a coincident accept.
      fifo_q = {4'h6, 4'h7, 4'h8};
      fifo_update();
      bus.dready = 1'b0;
      do_reset();
      repeat (7) step();
      chk("fl_pre_dvalid", 32'(bus.dvalid), 32'd1);
      chk("fl_pre_dout", 32'(bus.dout), 32'h6);
      chk("fl_pre_pop_cnt", 32'(pop_cnt), 32'd2);
      flush = 1'b1;
      bus.dready = 1'b1;
      #1;
      chk("fl_deq_low", 32'(bus.deq), 32'd0);
      step();
      flush = 1'b0;
      bus.dready = 1'b0;
      #1;
      chk("fl_dvalid", 32'(bus.dvalid), 32'd0);
      chk("fl_pop_cnt", 32'(pop_cnt), 32'd2);
      chk("fl_resume_deq", 32'(bus.deq), 32'd1);
      step();
      chk("fl_resume_dout", 32'(bus.dout), 32'h8);
      chk("fl_resume_pop_cnt", 32'(pop_cnt), 32'd3);
      fifo_q.push_back(4'h9);
      fifo_update();
      step();
      step();
      flush = 1'b1;
      #1;
      chk("fl_forces_deq", 32'(bus.deq), 32'd0);
      step();
      flush = 1'b0;
      #1;
      chk("fl2_dvalid", 32'(bus.dvalid), 32'd0);
      chk("fl2_pop_cnt", 32'(pop_cnt), 32'd3);
      chk("fl2_deq", 32'(bus.deq), 32'd1);
      step();
      chk("fl2_dout", 32'(bus.dout), 32'h9);
      chk("fl2_pop_cnt_wrap", 32'(pop_cnt), 32'd0);

      // Wrap after five pops, then disable mid-WAIT.
      fifo_q = {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
      fifo_update();
      bus.dready = 1'b1;
      en = 1'b1;
      do_reset();
      repeat (13) step();
      chk("wrap_pop_cnt", 32'(pop_cnt), 32'd1);
      chk("wrap_dout", 32'(bus.dout), 32'h5);
      chk("wrap_busy", 32'(busy), 32'd1);
      en = 1'b0;
      step();
      chk("dis_wait_busy", 32'(busy), 32'd1);
      chk("dis_dvalid", 32'(bus.dvalid), 32'd0);
      step();
      chk("dis_idle_busy", 32'(busy), 32'd0);
      n_deq = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.deq) n_deq++;
         step();
      end
      chk("dis_no_deq", 32'(n_deq), 32'd0);
      chk("dis_fifo_left", 32'(fifo_q.size()), 32'd2);
      en = 1'b1;
      #1;
      chk("reen_deq", 32'(bus.deq), 32'd1);
      step();
      chk("reen_dout", 32'(bus.dout), 32'h6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
Consumer-side front end for the 8-entry, 4-bit FIFO: the reader for the FIFO's writer. It watches empty/out, issues single-cycle deq pulses, and moves popped words into a 2-entry output buffer presented on a valid/ready stream. It sits between the FIFO's read port and any downstream consumer, such as the display path or a checker. It paces pops so the FIFO's head data and empty flag settle between pulses.

Parameters:
WIDTH, 4, data width; must match the FIFO data width
GAP, 2, idle cycles (>=1) with deq low after each deq pulse before the next pop is allowed
CNT_W, 8, width of the pop counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  pop enable; when 0 no new deq is issued, and the output stream still drains
flush  in  1  synchronous; discards buffered words
empty  in  1  FIFO empty flag
out  in  WIDTH  FIFO head data; valid whenever empty=0
deq  out  1  single-cycle pop pulse to the FIFO
dout  out  WIDTH  head of output buffer
dvalid  out  1  dout valid
dready  in  1  downstream accepts dout when dvalid&&dready
pop_cnt  out  CNT_W  number of deq pulses issued, wraps modulo 2^CNT_W
busy  out  1  1 when state!=IDLE or dvalid=1

Behaviour:
- Reset (rst=0, async): state=IDLE, deq=0, dvalid=0, dout=0, buffer count=0, gap counter=0, pop_cnt=0.
- Output buffer: 2-entry circular buffer (rd/wr pointers, 2-bit count). dvalid=(count!=0). dout=entry[rd] when count!=0, otherwise 0.
- State IDLE:
  - If en=1, empty=0, flush=0 and count<2: deq=1 this cycle only. out is written into entry[wr] at this edge, pop_cnt increments, and the state goes to WAIT with gap counter=GAP-1.
  - Otherwise deq=0 and the state stays IDLE.
- State WAIT: deq=0. The gap counter decrements each cycle. When it reaches 0, the state goes to IDLE. A pop is never issued in WAIT, so there is a minimum period of GAP+1 cycles between deq pulses.
- Latency: a word present at out while IDLE with space appears on dout/dvalid in the next cycle.
- Simultaneous push (deq) and downstream accept in one cycle: both happen; count is unchanged.
- A push is allowed at count=1 even when no accept occurs that cycle. A push is never issued at count=2, so there is no overflow path.
- Back-pressure: with dready=0 the block stops after 2 pops. deq stays 0 and FIFO contents are retained.
- flush=1:
  - count, rd and wr are cleared to 0 and dvalid drops the next cycle.
  - deq is forced to 0 that cycle.
  - The state goes to IDLE and pop_cnt is unchanged.
  - flush has priority over a coincident accept or push.
- en=0 in WAIT: the gap countdown still completes, then the block holds in IDLE.
- empty rising during WAIT is harmless; it is only sampled in IDLE.
- Reset mid-operation: every register returns to its reset value immediately. A deq pulse in progress is truncated.
- pop_cnt wraps from 2^CNT_W-1 to 0 with no flag.

Decomposition:
- Shared package: FIFO_W=4 (data width) and FIFO_DEPTH=8 (shared with the FIFO); reader state encoding IDLE=1'b0, WAIT=1'b1.
- One natural sub-module: reader_skid_buf, the 2-entry valid/ready buffer holding rd/wr/count.
- The pop FSM and the gap counter stay in fifo_reader.

Test Plan:
- Reset: hold rst=0 with empty=0, out=4'h5 -> deq=0, dvalid=0, dout=0, pop_cnt=0. Release rst -> first deq pulse one cycle later; dout=5, dvalid=1 on the next cycle.
- Paced drain: FIFO holds 2,3,4 with dready=1, GAP=2 -> deq pulses exactly 3 cycles apart; dout sequence 2,3,4; pop_cnt=3; no deq once empty=1.
- Back-pressure: FIFO holds 10..14 with dready=0 -> exactly 2 deq pulses and dout=10 held. Raise dready for 1 cycle -> dout=11, and a third pop follows after the gap.
- Empty: empty=1 with en=1 for 20 cycles -> deq never asserted, dvalid=0, busy=0.
- Flush: buffer holds 6,7 and flush=1 coincides with dready=1 -> next cycle dvalid=0 and pop_cnt unchanged; the next pop resumes with the FIFO head.
- Wrap/disable: with CNT_W=2, 5 pops -> pop_cnt=1. en=0 mid-stream -> the current WAIT completes and no further deq is issued.
